imm_gen_pipe: RTL and testbench

- Pipelined, parametrised immediate generator for the RV32I/RV64I decode stage.
- Accepts one 32-bit instruction per cycle over a valid/ready handshake.
- Emits the sign- or zero-extended XLEN-wide immediate, a format code and an illegal-opcode flag one cycle later.
- A 2-entry skid buffer decouples decode from execute backpressure without a combinational ready path.

---
 rtl/imm_gen_pipe.sv | 176 +++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe -- pipelined RV32I/RV64I immediate generator for the decode stage.
//
// Decodes the immediate, format code and illegal-opcode flag of one 32-bit
// instruction per cycle and presents them one cycle later. A main output
// register backed by a single skid register gives two entries of buffering,
// so in_ready is a pure register output (no combinational path from out_ready).
//
// Optional feature macro: IMM_GEN_ZICSR_EN
//   defined   : SYSTEM (1110011) decodes as fmt=Z with a zero-extended uimm
//               (funct3[2]=1) or CSR address (funct3[2]=0).
//   undefined : SYSTEM decodes as fmt=NONE, imm=0, legal.
//
// Parameters:
//   XLEN  immediate width, 32 or 64
//   RV64  1 enables OP-IMM-32 / OP-32 decode (must be 0 when XLEN=32)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   in_valid     instruction available
//   in_ready     block can accept (registered, = !skid_valid)
//   in_instr     raw 32-bit instruction word
//   out_valid    immediate available
//   out_ready    consumer accepts
//   out_imm      extended immediate, XLEN bits
//   out_fmt      0=NONE 1=I 2=S 3=B 4=U 5=J 6=Z 7=reserved
//   out_illegal  unrecognised opcode or instr[1:0] != 2'b11
module imm_gen_pipe #(
    parameter int XLEN = 32,
    parameter bit RV64 = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6,
        FMT_RSVD = 3'd7
    } fmt_e;

    logic [6:0]      opcode;
    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;
    logic            dec_illegal;

    fmt_e            main_fmt;
    logic            skid_valid;
    logic [XLEN-1:0] skid_imm;
    fmt_e            skid_fmt;
    logic            skid_illegal;

    logic            in_xfer;
    logic            out_xfer;

    assign opcode   = in_instr[6:0];
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;
    assign in_ready = ~skid_valid;
    assign out_fmt  = main_fmt;

    // Combinational decode of the presented instruction.
    always_comb begin
        dec_imm     = '0;
        dec_fmt     = FMT_NONE;
        dec_illegal = 1'b0;
        if (in_instr[1:0] != 2'b11) begin
            dec_illegal = 1'b1;
        end else begin
            case (opcode)
                7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111: begin
                    dec_fmt = FMT_I;
                    dec_imm = XLEN'($signed(in_instr[31:20]));
                end
                7'b0011011: begin
                    if (RV64) begin
                        dec_fmt = FMT_I;
                        dec_imm = XLEN'($signed(in_instr[31:20]));
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end
                7'b0100011: begin
                    dec_fmt = FMT_S;
                    dec_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
                end
                7'b1100011: begin
                    dec_fmt = FMT_B;
                    dec_imm = XLEN'($signed({in_instr[31], in_instr[7],
                                             in_instr[30:25], in_instr[11:8], 1'b0}));
                end
                7'b0110111, 7'b0010111: begin
                    dec_fmt = FMT_U;
                    dec_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
                end
                7'b1101111: begin
                    dec_fmt = FMT_J;
                    dec_imm = XLEN'($signed({in_instr[31], in_instr[19:12],
                                             in_instr[20], in_instr[30:21], 1'b0}));
                end
                7'b0110011: begin
                    dec_fmt = FMT_NONE;
                end
                7'b0111011: begin
                    dec_illegal = ~RV64;
                end
                7'b1110011: begin
`ifdef IMM_GEN_ZICSR_EN
                    dec_fmt = FMT_Z;
                    if (in_instr[14]) begin
                        dec_imm = XLEN'(in_instr[19:15]);
                    end else begin
                        dec_imm = XLEN'(in_instr[31:20]);
                    end
`else
                    dec_fmt = FMT_NONE;
`endif
                end
                default: begin
                    dec_illegal = 1'b1;
                end
            endcase
        end
    end

    // Two-entry buffer: main register drives the outputs, skid catches the
    // one entry accepted while main is stalled. in_ready is low exactly when
    // skid is occupied, so no input transfer can coincide with a skid entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_imm      <= '0;
            main_fmt     <= FMT_NONE;
            out_illegal  <= 1'b0;
            skid_valid   <= 1'b0;
            skid_imm     <= '0;
            skid_fmt     <= FMT_NONE;
            skid_illegal <= 1'b0;
        end else if (skid_valid) begin
            if (out_xfer) begin
                out_imm     <= skid_imm;
                main_fmt    <= skid_fmt;
                out_illegal <= skid_illegal;
                skid_valid  <= 1'b0;
            end
        end else if (in_xfer) begin
            if (!out_valid || out_ready) begin
                out_valid   <= 1'b1;
                out_imm     <= dec_imm;
                main_fmt    <= dec_fmt;
                out_illegal <= dec_illegal;
            end else begin
                skid_valid   <= 1'b1;
                skid_imm     <= dec_imm;
                skid_fmt     <= dec_fmt;
                skid_illegal <= dec_illegal;
            end
        end else if (out_xfer) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe -- self-checking bench for imm_gen_pipe.
//
// Two instances share stimulus: XLEN=32/RV64=0 and XLEN=64/RV64=1. A queue per
// instance models buffer contents (occupancy gives out_valid and in_ready,
// the queue head gives the expected outputs); expected decodes come from
// instruction-field arithmetic. Directed steps with literal expectations are
// followed by a randomized phase.
module tb_imm_gen_pipe;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        out_ready;

    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_imm32;
    logic [2:0]  out_fmt32;
    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt64;

    int ntests = 0;
    int nfail  = 0;

    exp_t q32[$];
    exp_t q64[$];

    logic        stalled;
    logic [31:0] held_imm32;
    logic [2:0]  held_fmt32;
    logic        held_ill32;

    imm_gen_pipe #(.XLEN(32), .RV64(1'b0)) dut32 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready32),
        .in_instr    (in_instr),
        .out_valid   (out_valid32),
        .out_ready   (out_ready),
        .out_imm     (out_imm32),
        .out_fmt     (out_fmt32),
        .out_illegal (out_illegal32)
    );

    imm_gen_pipe #(.XLEN(64), .RV64(1'b1)) dut64 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready64),
        .in_instr    (in_instr),
        .out_valid   (out_valid64),
        .out_ready   (out_ready),
        .out_imm     (out_imm64),
        .out_fmt     (out_fmt64),
        .out_illegal (out_illegal64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode from the ISA field definitions using signed arithmetic.
    function automatic exp_t ref_decode(input logic [31:0] i, input bit wide);
        exp_t   e;
        longint v;
        int     si;
        int     hi;
        int     sg;
        logic [6:0] op;
        logic [2:0] f;
        logic       ill;
        si  = $signed(i);
        sg  = si >>> 31;
        op  = i[6:0];
        v   = 0;
        f   = 3'd0;
        ill = 1'b0;
        if (i[1:0] != 2'b11) begin
            ill = 1'b1;
        end else begin
            case (op)
                7'h13, 7'h03, 7'h67, 7'h0f: begin
                    f = 3'd1; hi = si >>> 20; v = longint'(hi);
                end
                7'h1b: begin
                    if (wide) begin
                        f = 3'd1; hi = si >>> 20; v = longint'(hi);
                    end else begin
                        ill = 1'b1;
                    end
                end
                7'h23: begin
                    f = 3'd2; hi = si >>> 25;
                    v = longint'(hi) * 32 + longint'(i[11:7]);
                end
                7'h63: begin
                    f = 3'd3;
                    v = longint'(sg) * 4096 + longint'(i[7]) * 2048
                      + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
                end
                7'h37, 7'h17: begin
                    f = 3'd4; hi = si >>> 12; v = longint'(hi) * 4096;
                end
                7'h6f: begin
                    f = 3'd5;
                    v = longint'(sg) * 1048576 + longint'(i[19:12]) * 4096
                      + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
                end
                7'h33: f = 3'd0;
                7'h3b: ill = !wide;
                7'h73: begin
`ifdef IMM_GEN_ZICSR_EN
                    f = 3'd6;
                    v = i[14] ? longint'(i[19:15]) : longint'(i[31:20]);
`else
                    f = 3'd0;
`endif
                end
                default: ill = 1'b1;
            endcase
        end
        e.imm = wide ? 64'(v) : {32'b0, 32'(v)};
        e.fmt = f;
        e.ill = ill;
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare both instances against the queue model at the negedge, then
    // record the handshakes that the coming posedge will perform.
    task automatic cycle();
        bit in_x;
        bit out_x;
        @(negedge clk);
        check("m32_valid", {63'b0, out_valid32}, {63'b0, q32.size() != 0});
        check("m32_ready", {63'b0, in_ready32},  {63'b0, q32.size() < 2});
        check("m64_valid", {63'b0, out_valid64}, {63'b0, q64.size() != 0});
        check("m64_ready", {63'b0, in_ready64},  {63'b0, q64.size() < 2});
        if (q32.size() != 0) begin
            check("m32_imm", {32'b0, out_imm32},    q32[0].imm);
            check("m32_fmt", {61'b0, out_fmt32},    {61'b0, q32[0].fmt});
            check("m32_ill", {63'b0, out_illegal32}, {63'b0, q32[0].ill});
        end
        if (q64.size() != 0) begin
            check("m64_imm", out_imm64,              q64[0].imm);
            check("m64_fmt", {61'b0, out_fmt64},     {61'b0, q64[0].fmt});
            check("m64_ill", {63'b0, out_illegal64}, {63'b0, q64[0].ill});
        end
        if (stalled) begin
            check("hold_imm", {32'b0, out_imm32},     {32'b0, held_imm32});
            check("hold_fmt", {61'b0, out_fmt32},     {61'b0, held_fmt32});
            check("hold_ill", {63'b0, out_illegal32}, {63'b0, held_ill32});
        end
        stalled    = out_valid32 && !out_ready;
        held_imm32 = out_imm32;
        held_fmt32 = out_fmt32;
        held_ill32 = out_illegal32;
        in_x  = in_valid && in_ready32;
        out_x = out_valid32 && out_ready;
        if (out_x && q32.size() != 0) begin
            void'(q32.pop_front());
            void'(q64.pop_front());
        end
        if (in_x) begin
            q32.push_back(ref_decode(in_instr, 1'b0));
            q64.push_back(ref_decode(in_instr, 1'b1));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic expect32(input string tag, input logic [31:0] imm,
                            input logic [2:0] fmt, input logic ill);
        check({tag, "_v"},   {63'b0, out_valid32},   64'd1);
        check({tag, "_imm"}, {32'b0, out_imm32},     {32'b0, imm});
        check({tag, "_fmt"}, {61'b0, out_fmt32},     {61'b0, fmt});
        check({tag, "_ill"}, {63'b0, out_illegal32}, {63'b0, ill});
    endtask

    task automatic expect64(input string tag, input logic [63:0] imm,
                            input logic [2:0] fmt, input logic ill);
        check({tag, "_v"},   {63'b0, out_valid64},   64'd1);
        check({tag, "_imm"}, out_imm64,              imm);
        check({tag, "_fmt"}, {61'b0, out_fmt64},     {61'b0, fmt});
        check({tag, "_ill"}, {63'b0, out_illegal64}, {63'b0, ill});
    endtask

    localparam logic [31:0] INS_SW   = 32'hFE512E23;
    localparam logic [31:0] INS_BEQ  = 32'hFE000CE3;
    localparam logic [31:0] INS_LUI  = 32'h123450B7;
    localparam logic [31:0] INS_JAL  = 32'h001000EF;
    localparam logic [31:0] INS_ADDI = 32'hFFF00093;
    localparam logic [31:0] INS_CSR  = 32'h3402D073;

    logic [6:0] legal_ops [13] = '{7'h13, 7'h03, 7'h67, 7'h0f, 7'h1b, 7'h23, 7'h63,
                                   7'h37, 7'h17, 7'h6f, 7'h33, 7'h3b, 7'h73};

    initial begin
        logic [31:0] r;
        stalled   = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {63'b0, out_valid32}, 64'd0);
        check("rst_ready", {63'b0, in_ready32},  64'd1);
        check("rst_imm",   out_imm64,            64'd0);
        check("rst_fmt",   {61'b0, out_fmt32},   64'd0);
        rst_n = 1'b1;
        cycle();

        // Single store, 1-cycle latency.
        in_valid = 1'b1; in_instr = INS_SW;
        cycle();
        in_valid = 1'b0;
        expect32("sw", 32'hFFFFFFFC, 3'd2, 1'b0);
        cycle();

        // Back-to-back B, U, J.
        in_valid = 1'b1; in_instr = INS_BEQ;
        cycle();
        expect32("beq", 32'hFFFFFFF8, 3'd3, 1'b0);
        in_instr = INS_LUI;
        cycle();
        expect32("lui", 32'h12345000, 3'd4, 1'b0);
        in_instr = INS_JAL;
        cycle();
        expect32("jal", 32'h00000800, 3'd5, 1'b0);

        // 64-bit sign extension and the all-zero word.
        in_instr = INS_ADDI;
        cycle();
        expect64("addi64", 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
        in_instr = 32'h00000000;
        cycle();
        expect64("zero64", 64'd0, 3'd0, 1'b1);
        expect32("zero32", 32'd0, 3'd0, 1'b1);

        // SYSTEM opcode with and without the CSR feature.
        in_instr = INS_CSR;
        cycle();
`ifdef IMM_GEN_ZICSR_EN
        expect32("csr", 32'h5, 3'd6, 1'b0);
`else
        expect32("csr", 32'h0, 3'd0, 1'b0);
`endif
        in_valid = 1'b0;
        cycle();

        // Backpressure: A, B fill the buffer, C waits; drain in order.
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = INS_SW;
        cycle();
        expect32("bp_a0", 32'hFFFFFFFC, 3'd2, 1'b0);
        in_instr = INS_LUI;
        cycle();
        check("bp_full_ready", {63'b0, in_ready32}, 64'd0);
        expect32("bp_a1", 32'hFFFFFFFC, 3'd2, 1'b0);
        in_instr = INS_JAL;
        cycle();
        cycle();
        check("bp_c_ready", {63'b0, in_ready32}, 64'd0);
        expect32("bp_a2", 32'hFFFFFFFC, 3'd2, 1'b0);
        out_ready = 1'b1;
        cycle();
        expect32("bp_b", 32'h12345000, 3'd4, 1'b0);
        check("bp_ready_up", {63'b0, in_ready32}, 64'd1);
        cycle();
        expect32("bp_c", 32'h00000800, 3'd5, 1'b0);
        in_valid = 1'b0;
        cycle();
        check("bp_empty", {63'b0, out_valid32}, 64'd0);

        // Reset with two entries buffered.
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = INS_BEQ;
        cycle();
        in_instr = INS_LUI;
        cycle();
        check("pre_rst_ready", {63'b0, in_ready32}, 64'd0);
        rst_n = 1'b0;
        in_instr = INS_JAL;
        @(posedge clk);
        #1;
        check("mid_rst_valid32", {63'b0, out_valid32}, 64'd0);
        check("mid_rst_valid64", {63'b0, out_valid64}, 64'd0);
        check("mid_rst_ready",   {63'b0, in_ready32},  64'd1);
        check("mid_rst_imm",     {32'b0, out_imm32},   64'd0);
        check("mid_rst_ill",     {63'b0, out_illegal32}, 64'd0);
        q32.delete();
        q64.delete();
        stalled = 1'b0;
        rst_n = 1'b1;
        out_ready = 1'b1;
        cycle();
        expect32("post_rst", 32'h00000800, 3'd5, 1'b0);
        in_valid = 1'b0;
        cycle();

        // Randomized traffic against the queue model.
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            r = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                in_instr = {r[31:7], legal_ops[$urandom_range(0, 12)]};
            end else begin
                in_instr = r;
            end
            cycle();
        end

        // Drain, bounded.
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) cycle();
        check("drain_empty", {63'b0, out_valid32}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
